serial_transmitter: RTL and testbench

Byte-to-serial framer that drives the serial line consumed by the team's serial receiver. It accepts bytes over a valid/ready handshake into a one-entry holding buffer. Each byte is emitted as a frame: start bit (0), 8 data bits LSB first, an optional parity bit, then 1 or 2 stop bits (1). The line idles high. With default parameters each bit lasts one clock, which matches the receiver's one-bit-per-clock sampling.

---
 rtl/serial_transmitter.sv | 155 +++++++++++++++
 tb/tb_serial_transmitter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module : serial_transmitter
// Byte-to-serial framer: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, fed through a one-entry holding buffer.
// Rev    : 1.0
// ============================================================================
module serial_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [c_baud_w-1:0] c_baud_pre  = c_baud_w'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic c_stop_last = (STOP_BITS == 2);
  localparam logic c_par_odd   = (PARITY_ODD != 0);
  localparam logic c_one_clk   = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_baud_w-1:0]   r_baud;
  logic [2:0]            r_bit_cnt;
  logic                  r_stop_cnt;
  logic [7:0]            r_shift;
  logic                  r_parity;
  logic [7:0]            r_buf;
  logic                  r_buf_full;
  logic                  r_serial;
  logic                  r_busy;
  logic                  r_frame_done;

  logic w_bit_end;
  logic w_last_stop;
  logic w_load;

  assign w_bit_end   = (r_baud == c_baud_last);
  assign w_last_stop = (r_stop_cnt == c_stop_last);
  // Unload either from idle or straight out of the final stop bit (contiguous frames)
  assign w_load = r_buf_full &&
                  ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end && w_last_stop));

  assign tx_ready   = !r_buf_full;
  assign serial_out = r_serial;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_buf        <= '0;
      r_buf_full   <= 1'b0;
      r_serial     <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (tx_valid && !r_buf_full) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
      end

      if (w_load) begin
        r_shift    <= r_buf;
        r_parity   <= (^r_buf) ^ c_par_odd;
        r_buf_full <= 1'b0;
        r_state    <= S_START;
        r_serial   <= 1'b0;
        r_busy     <= 1'b1;
        r_baud     <= '0;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
      end else if (r_state != S_IDLE) begin
        if (!w_bit_end) begin
          r_baud <= r_baud + 1'b1;
          // Pulse lands on the final clock of the final stop bit
          if (r_state == S_STOP && w_last_stop && r_baud == c_baud_pre)
            r_frame_done <= 1'b1;
        end else begin
          r_baud <= '0;
          unique case (r_state)
            S_START: begin
              r_state   <= S_DATA;
              r_serial  <= r_shift[0];
              r_bit_cnt <= '0;
            end
            S_DATA: begin
              if (r_bit_cnt != 3'd7) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {1'b0, r_shift[7:1]};
                r_serial  <= r_shift[1];
              end else if (PARITY_EN != 0) begin
                r_state  <= S_PARITY;
                r_serial <= r_parity;
              end else begin
                r_state      <= S_STOP;
                r_stop_cnt   <= 1'b0;
                r_serial     <= 1'b1;
                r_frame_done <= c_one_clk && !c_stop_last;
              end
            end
            S_PARITY: begin
              r_state      <= S_STOP;
              r_stop_cnt   <= 1'b0;
              r_serial     <= 1'b1;
              r_frame_done <= c_one_clk && !c_stop_last;
            end
            S_STOP: begin
              if (!w_last_stop) begin
                r_stop_cnt   <= 1'b1;
                r_serial     <= 1'b1;
                r_frame_done <= c_one_clk;
              end else begin
                r_state  <= S_IDLE;
                r_serial <= 1'b1;
                r_busy   <= 1'b0;
              end
            end
            default: begin
              r_state  <= S_IDLE;
              r_serial <= 1'b1;
              r_busy   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_transmitter
// Bench for serial_transmitter: four parameterisations against a frame-queue model.
// Rev    : 1.0
// ============================================================================
module tb_serial_transmitter;

  typedef bit bitq_t[$];

  logic       clk;
  logic       reset;
  logic [7:0] tx_data [4];
  logic [3:0] tx_valid;
  wire  [3:0] tx_ready;
  wire  [3:0] serial_out;
  wire  [3:0] busy;
  wire  [3:0] frame_done;

  int checks   = 0;
  int failures = 0;

  // Per-instance parameters, mirrored for the model
  int pe_t  [4] = '{0, 1, 1, 0};
  int po_t  [4] = '{0, 0, 1, 0};
  int sb_t  [4] = '{1, 1, 1, 2};
  int cpb_t [4] = '{1, 1, 1, 4};

  serial_transmitter #(.CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
    .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .serial_out(serial_out[0]), .busy(busy[0]), .frame_done(frame_done[0]));
  serial_transmitter #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
    .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .serial_out(serial_out[1]), .busy(busy[1]), .frame_done(frame_done[1]));
  serial_transmitter #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_d2 (
    .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .serial_out(serial_out[2]), .busy(busy[2]), .frame_done(frame_done[2]));
  serial_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d3 (
    .clk(clk), .reset(reset), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .serial_out(serial_out[3]), .busy(busy[3]), .frame_done(frame_done[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t got=0x%0h exp=0x%0h", nm, idx, $time, act, exp);
    end
  endtask

  // Whole frame as a per-clock list of line levels
  function automatic bitq_t frame_bits(input logic [7:0] b, input int pe, input int po,
                                       input int sb, input int cpb);
    bitq_t bits;
    bitq_t q;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
    if (pe != 0) bits.push_back((^b) ^ (po != 0));
    for (int k = 0; k < sb; k++) bits.push_back(1'b1);
    foreach (bits[k]) for (int c = 0; c < cpb; c++) q.push_back(bits[k]);
    return q;
  endfunction

  // Model: remaining line levels of the current frame plus a one-byte buffer
  bitq_t      line_q [4];
  bit         m_full [4] = '{0, 0, 0, 0};
  logic [7:0] m_buf  [4];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        line_q[i].delete();
        m_full[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        bit acc;
        acc = tx_valid[i] && !m_full[i];
        if (line_q[i].size() > 0) void'(line_q[i].pop_front());
        if (line_q[i].size() == 0 && m_full[i]) begin
          line_q[i] = frame_bits(m_buf[i], pe_t[i], po_t[i], sb_t[i], cpb_t[i]);
          m_full[i] = 1'b0;
        end
        if (acc) begin
          m_full[i] = 1'b1;
          m_buf[i]  = tx_data[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk("line",  i, 64'(serial_out[i]), 64'((line_q[i].size() > 0) ? line_q[i][0] : 1'b1));
      chk("busy",  i, 64'(busy[i]),       64'(line_q[i].size() > 0));
      chk("fdone", i, 64'(frame_done[i]), 64'(line_q[i].size() == 1));
      chk("ready", i, 64'(tx_ready[i]),   64'(!m_full[i]));
    end
  end

  // Logger: line level of every busy clock, and frame_done pulse counts
  bitq_t cap_q [4];
  int    fdn   [4] = '{0, 0, 0, 0};

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (busy[i]) cap_q[i].push_back(serial_out[i]);
        if (frame_done[i]) fdn[i]++;
      end
    end
  end

  function automatic logic [63:0] capvec(input int i, input int base);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 64 && base + k < cap_q[i].size(); k++) v[k] = cap_q[i][base + k];
    return v;
  endfunction

  // Independent line decoder on instance 0 for the loopback run
  bit         rx_en  = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] sent [100];

  initial begin
    logic [7:0] r;
    forever begin
      @(negedge clk);
      if (rx_en && serial_out[0] == 1'b0) begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          r[k] = serial_out[0];
        end
        @(negedge clk);
        chk("rx_stop", rx_cnt, 64'(serial_out[0]), 64'd1);
        if (rx_cnt < 100) chk("rx_byte", rx_cnt, 64'(r), 64'(sent[rx_cnt]));
        rx_cnt++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int i, input logic [7:0] b, input bit release_after);
    int n;
    n = 0;
    tx_valid[i] = 1'b1;
    tx_data[i]  = b;
    while (!tx_ready[i] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("send_timeout", i, 64'(n), 64'd0);
    @(negedge clk);
    if (release_after) tx_valid[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  int base [4];
  int zeros;

  initial begin
    reset    = 1'b0;
    tx_valid = 4'b0;
    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_line",  0, 64'(serial_out), 64'hF);
    chk("rst_ready", 0, 64'(tx_ready),   64'hF);
    chk("rst_busy",  0, 64'(busy),       64'h0);
    chk("rst_fdone", 0, 64'(frame_done), 64'h0);
    reset = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame, default parameters
    base[0] = cap_q[0].size();
    fdn[0]  = 0;
    send(0, 8'hA5, 1'b1);
    repeat (15) @(negedge clk);
    chk("a5_bits", 0, capvec(0, base[0]), 64'h34A);
    chk("a5_len",  0, 64'(cap_q[0].size() - base[0]), 64'd10);
    chk("a5_fd",   0, 64'(fdn[0]), 64'd1);

    // Back-to-back 0x00 then 0xFF with valid held
    base[0] = cap_q[0].size();
    send(0, 8'h00, 1'b0);
    send(0, 8'hFF, 1'b1);
    repeat (25) @(negedge clk);
    chk("b2b_bits", 0, capvec(0, base[0]), 64'hFFA00);
    chk("b2b_len",  0, 64'(cap_q[0].size() - base[0]), 64'd20);

    // Even and odd parity on 0xA5
    base[1] = cap_q[1].size();
    base[2] = cap_q[2].size();
    send(1, 8'hA5, 1'b1);
    send(2, 8'hA5, 1'b1);
    repeat (15) @(negedge clk);
    chk("par_even", 1, capvec(1, base[1]), 64'h54A);
    chk("par_odd",  2, capvec(2, base[2]), 64'h74A);
    chk("par_len",  1, 64'(cap_q[1].size() - base[1]), 64'd11);
    chk("par_len",  2, 64'(cap_q[2].size() - base[2]), 64'd11);

    // 4 clocks per bit, two stop bits, byte 0x01
    base[3] = cap_q[3].size();
    fdn[3]  = 0;
    send(3, 8'h01, 1'b1);
    repeat (50) @(negedge clk);
    chk("slow_bits", 3, capvec(3, base[3]), 64'hFF0000000F0);
    chk("slow_len",  3, 64'(cap_q[3].size() - base[3]), 64'd44);
    chk("slow_fd",   3, 64'(fdn[3]), 64'd1);

    // Reset during data bit 3 of 0x3C with a second byte buffered
    send(0, 8'h3C, 1'b1);
    send(0, 8'h55, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy",  0, 64'(busy[0]),     64'd1);
    chk("pre_rst_ready", 0, 64'(tx_ready[0]), 64'd0);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_line",  0, 64'(serial_out[0]), 64'd1);
    chk("mid_rst_ready", 0, 64'(tx_ready[0]),   64'd1);
    chk("mid_rst_busy",  0, 64'(busy[0]),       64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    zeros = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (serial_out[0] == 1'b0 || busy[0]) zeros++;
    end
    chk("post_rst_idle", 0, 64'(zeros), 64'd0);

    // Loopback of 100 random bytes
    rx_en = 1'b1;
    for (int n = 0; n < 100; n++) begin
      sent[n] = 8'($urandom_range(0, 255));
      send(0, sent[n], (n == 99));
    end
    repeat (30) @(negedge clk);
    rx_en = 1'b0;
    chk("rx_count", 0, 64'(rx_cnt), 64'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
